// File: rtl/midi_pkg.sv
// midi_pkg: shared types and constants for the MIDI transmit/receive path.
// The optional running-status feature is controlled by MIDI_RUNNING_STATUS_EN.
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int MIDI_BAUD            = 31250;
    localparam int CLK_HZ               = 4_000_000;
    localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / MIDI_BAUD;

    localparam logic [7:0] STATUS_MIN = 8'h80;
    localparam logic [7:0] CHAN_MAX   = 8'hEF;
    localparam logic [7:0] SYSCOM_MAX = 8'hF7;
    localparam logic [7:0] RT_MIN     = 8'hF8;

    // Channel voice/mode status bytes take part in running status.
    function automatic logic is_channel_status(input logic [7:0] b);
        return (b >= STATUS_MIN) && (b <= CHAN_MAX);
    endfunction

    // System common bytes cancel any running status.
    function automatic logic is_system_common(input logic [7:0] b);
        return (b > CHAN_MAX) && (b <= SYSCOM_MAX);
    endfunction

    // Real-time bytes may interleave anywhere without affecting status.
    function automatic logic is_realtime(input logic [7:0] b);
        return b >= RT_MIN;
    endfunction

endpackage

// File: rtl/midi_baud_timer.sv
// midi_baud_timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
// Holds at the terminal count until cleared; shared with the receiver sampler.
module midi_baud_timer #(
    parameter int CLKS_PER_BIT = 128
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Next count: restart on clear, otherwise advance until the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/midi_transmitter.sv
// midi_transmitter: valid/ready byte input, 8N1 serial MIDI output on tx.
// Defining MIDI_RUNNING_STATUS_EN drops repeated channel status bytes.
module midi_transmitter
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    tx_state_t  state_q;
    logic       tx_q;
    logic       busy_q;
    logic [7:0] shift_q;
    logic [2:0] idx_q;
    logic       tick;
    logic       timer_clear;
    logic       suppress;

    assign ready = (state_q == IDLE) && !reset;
    assign tx    = tx_q;
    assign busy  = busy_q;

    // The bit timer sits at zero while idle and restarts at every bit boundary.
    assign timer_clear = (state_q == IDLE) || tick;

    midi_baud_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(timer_clear),
        .tick (tick)
    );

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status_q;

    assign suppress = is_channel_status(data) && (data == last_status_q);

    // Track the running status as bytes are accepted from upstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_status_q <= 8'h00;
        end else if (valid && ready) begin
            if (is_channel_status(data)) begin
                last_status_q <= data;
            end else if (is_system_common(data)) begin
                last_status_q <= 8'h00;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    // Frame sequencer: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            shift_q <= 8'h00;
            idx_q   <= 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (valid && !suppress) begin
                        shift_q <= data;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        idx_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_transmitter.sv
// tb_midi_transmitter: directed checks of the MIDI transmitter at 4 clocks/bit.
// Running-status expectations follow MIDI_RUNNING_STATUS_EN.
module tb_midi_transmitter;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;

    int testCount = 0;
    int failCount = 0;

    midi_transmitter #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .data (data),
        .valid(valid),
        .ready(ready),
        .tx   (tx),
        .busy (busy)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Drive the upstream handshake inputs.
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        valid = v;
        data  = d;
    endtask

    // One counted comparison with failure reporting.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles after the handshake for byte b.
    function automatic logic expBit(input logic [7:0] b, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    // Handshake byte b, then check every cycle of its frame and the idle cycle after it.
    task automatic runFrame(input string tag, input logic [7:0] b, input bit holdValid,
                            input logic [7:0] nextData, input int pulseAt);
        applyStimulus(1'b1, b);
        checkOutput({tag, " ready before"}, {7'd0, ready}, 8'd1);
        @(negedge clk);
        applyStimulus(holdValid, nextData);
        for (int k = 0; k < 10 * CPB; k++) begin
            checkOutput($sformatf("%s tx[%0d]", tag, k), {7'd0, tx}, {7'd0, expBit(b, k)});
            checkOutput($sformatf("%s busy[%0d]", tag, k), {7'd0, busy}, 8'd1);
            checkOutput($sformatf("%s ready[%0d]", tag, k), {7'd0, ready}, 8'd0);
            if (k == pulseAt) applyStimulus(1'b1, 8'h12);
            else if (k == pulseAt + 1) applyStimulus(1'b0, 8'h00);
            @(negedge clk);
        end
        checkOutput({tag, " idle tx"}, {7'd0, tx}, 8'd1);
        checkOutput({tag, " idle busy"}, {7'd0, busy}, 8'd0);
        checkOutput({tag, " idle ready"}, {7'd0, ready}, 8'd1);
    endtask

    // Offer a byte that should be swallowed without starting a frame.
    task automatic sendSuppressed(input string tag, input logic [7:0] b);
        applyStimulus(1'b1, b);
        checkOutput({tag, " ready"}, {7'd0, ready}, 8'd1);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s tx[%0d]", tag, k), {7'd0, tx}, 8'd1);
            checkOutput($sformatf("%s busy[%0d]", tag, k), {7'd0, busy}, 8'd0);
            checkOutput($sformatf("%s ready[%0d]", tag, k), {7'd0, ready}, 8'd1);
            @(negedge clk);
        end
    endtask

    // Directed sequence: reset, single frame, back-to-back, reset abort, ignored valid, running status.
    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            checkOutput("reset tx", {7'd0, tx}, 8'd1);
            checkOutput("reset busy", {7'd0, busy}, 8'd0);
            checkOutput("reset ready", {7'd0, ready}, 8'd0);
            @(negedge clk);
        end
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            checkOutput("post-reset tx", {7'd0, tx}, 8'd1);
            checkOutput("post-reset busy", {7'd0, busy}, 8'd0);
            checkOutput("post-reset ready", {7'd0, ready}, 8'd1);
        end

        runFrame("single 90", 8'h90, 1'b0, 8'h00, -10);

        runFrame("b2b 55", 8'h55, 1'b1, 8'hAA, -10);
        runFrame("b2b AA", 8'hAA, 1'b0, 8'h00, -10);

        applyStimulus(1'b1, 8'hFF);
        checkOutput("abort ready before", {7'd0, ready}, 8'd1);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00);
        for (int k = 0; k < 15; k++) begin
            checkOutput($sformatf("abort tx[%0d]", k), {7'd0, tx}, {7'd0, expBit(8'hFF, k)});
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort tx in reset", {7'd0, tx}, 8'd1);
        checkOutput("abort busy in reset", {7'd0, busy}, 8'd0);
        checkOutput("abort ready in reset", {7'd0, ready}, 8'd0);
        reset = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            checkOutput("abort residual tx", {7'd0, tx}, 8'd1);
            checkOutput("abort residual busy", {7'd0, busy}, 8'd0);
            checkOutput("abort residual ready", {7'd0, ready}, 8'd1);
        end

        runFrame("busy pulse 3C", 8'h3C, 1'b0, 8'h00, 10);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("ignored pulse tx", {7'd0, tx}, 8'd1);
            checkOutput("ignored pulse busy", {7'd0, busy}, 8'd0);
        end
        runFrame("after pulse 21", 8'h21, 1'b0, 8'h00, -10);

`ifdef MIDI_RUNNING_STATUS_EN
        runFrame("rs 90", 8'h90, 1'b0, 8'h00, -10);
        runFrame("rs 3C", 8'h3C, 1'b0, 8'h00, -10);
        runFrame("rs 40", 8'h40, 1'b0, 8'h00, -10);
        sendSuppressed("rs dup 90", 8'h90);
        runFrame("rs 3C b", 8'h3C, 1'b0, 8'h00, -10);
        runFrame("rs 00", 8'h00, 1'b0, 8'h00, -10);
        runFrame("rs F8", 8'hF8, 1'b0, 8'h00, -10);
        sendSuppressed("rs dup 90 after rt", 8'h90);
        runFrame("rs F0", 8'hF0, 1'b0, 8'h00, -10);
        runFrame("rs 90 after F0", 8'h90, 1'b0, 8'h00, -10);
`else
        runFrame("seq 90", 8'h90, 1'b0, 8'h00, -10);
        runFrame("seq 3C", 8'h3C, 1'b0, 8'h00, -10);
        runFrame("seq 40", 8'h40, 1'b0, 8'h00, -10);
        runFrame("seq 90 b", 8'h90, 1'b0, 8'h00, -10);
        runFrame("seq 3C b", 8'h3C, 1'b0, 8'h00, -10);
        runFrame("seq 00", 8'h00, 1'b0, 8'h00, -10);
        runFrame("seq F8", 8'hF8, 1'b0, 8'h00, -10);
        runFrame("seq 90 c", 8'h90, 1'b0, 8'h00, -10);
        runFrame("seq F0", 8'hF0, 1'b0, 8'h00, -10);
        runFrame("seq 90 d", 8'h90, 1'b0, 8'h00, -10);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
